data_sram_ctrl: RTL and testbench
=================================

Name: data_sram_ctrl

Overview:
- Sequences every data-SRAM access issued by the MEM stage over a variable-latency req/ack memory port.
- Generates byte strobes and replicated store data, and extracts and extends load data for lb/lbu/lh/lhu/lw.
- Raises a stall request toward the pipeline controller while an access is in flight, and flags misaligned accesses.

Parameters:
- MAX_WAIT, 255, cycles in BUSY without mem_ack before timeout; used only when the optional feature is compiled in.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels or drops the current access
- req_valid  in  1  access request from the MEM stage
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- stallreq  out  1  hold the pipeline
- excp_ale  out  1  address/size error; combinational
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  access timed out; qualified by resp_valid
- resp_rdata  out  32  extended load data; 0 for stores
- mem_req  out  1  memory request
- mem_wen  out  4  byte strobes; 0000 = read
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_ack  in  1  access complete; mem_rdata valid this cycle
- mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; all outputs 0; latched request, drop flag and counter cleared.
  - Reset mid-access abandons the access.
  - mem_ack arriving in IDLE or DONE is ignored.
- States:
  - IDLE -> BUSY when req_valid & ~excp_ale & ~flush; addr, size, signed, we and wdata are latched that cycle.
  - BUSY -> DONE on mem_ack.
  - DONE -> IDLE unconditionally.
- Misalignment: excp_ale = req_valid & IDLE & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)).
  - No access is started and stallreq stays 0.
- stallreq = (IDLE & req_valid & ~excp_ale & ~flush) | BUSY.
  - stallreq is 0 in DONE, so the pipeline advances exactly once per access.
  - req_valid in DONE is never captured.
- mem_req = BUSY; mem_addr, mem_wen and mem_wdata are registered and stable throughout BUSY.
  - Minimum latency: capture cycle N, mem_req in N+1; if ack in N+1, resp_valid in N+2.
- Store strobes:
  - byte: 0001<<addr[1:0], wdata {4{b[7:0]}}
  - half: 0011<<addr[1:0], wdata {2{h[15:0]}}
  - word: 1111, wdata unchanged
- Load data:
  - mem_rdata is registered on ack.
  - The byte/half lane is selected by latched addr[1:0] and zero- or sign-extended per latched signed.
  - Presented on resp_rdata in DONE.
- resp_valid = DONE & ~drop.
- Flush:
  - In IDLE, flush blocks capture.
  - In BUSY, flush sets drop; the access completes on the bus but its resp_valid is suppressed.
  - drop clears on entering IDLE.

Optional Feature:
- Macro DATA_SRAM_TIMEOUT_EN.
- With the macro: a counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches MAX_WAIT, the controller goes to DONE with resp_err=1 and resp_rdata=0.
  - A later stray ack is ignored.
- Without the macro: no counter, resp_err tied 0, BUSY waits indefinitely.

Decomposition:
- Shared package holds size encodings (SZ_B/SZ_H/SZ_W), FSM state encoding (IDLE/BUSY/DONE), and the strobe and lane constants.
- One sub-module, data_sram_load_align: purely combinational lane select plus extension; input (rdata, addr[1:0], size, signed), output rdata32.

Test Plan:
- lb addr 0x1003, signed, ack after 2 cycles, rdata 0x80AABBCC -> resp_rdata 0xFFFFFF80; stallreq high 3 cycles.
- sh addr 0x2002, wdata 0x00001234 -> mem_wen 1100, mem_wdata 0x12341234, mem_addr 0x2000; resp_rdata 0.
- lw addr 0x3001 -> excp_ale=1 same cycle; mem_req never asserted; stallreq 0.
- Flush asserted during BUSY of lhu 0x4002 -> ack completes; no resp_valid; IDLE next.
- Back-to-back lw 0x10 then lw 0x14, ack each in 1 cycle -> two resp_valid pulses 3 cycles apart; no duplicate capture in DONE.
- With DATA_SRAM_TIMEOUT_EN and MAX_WAIT=4, no ack -> resp_valid and resp_err after 4 BUSY cycles; later ack ignored.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// data_sram_ctrl_pkg
// Shared definitions for the data-SRAM controller slice: access size
// encodings, controller state encoding, byte-strobe patterns, load lane
// widths and the alignment check used by the controller.
// No ports (package).

package data_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   // Strobe patterns before shifting into the addressed lane
   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   localparam int LANE_B = 8;
   localparam int LANE_H = 16;

   // Byte accesses are always aligned; the illegal size counts as an error
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// data_sram_ctrl_if
// Bundles the MEM-stage request/response signals and the req/ack memory
// port of the data-SRAM controller.
//   slave  modport: the controller (takes requests, drives the memory port)
//   master modport: the pipeline/memory side (issues requests, returns acks)
// Signals:
//   flush, req_valid, req_we, req_size[1:0], req_signed, req_addr[31:0],
//   req_wdata[31:0]                       - access request from MEM stage
//   stallreq, excp_ale, resp_valid, resp_err, resp_rdata[31:0]
//                                         - status/completion to pipeline
//   mem_req, mem_wen[3:0], mem_addr[31:0], mem_wdata[31:0]
//                                         - memory request
//   mem_ack, mem_rdata[31:0]              - memory completion

interface data_sram_ctrl_if;

   logic        flush;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        stallreq;
   logic        excp_ale;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   logic        mem_req;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  flush, req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output stallreq, excp_ale, resp_valid, resp_err, resp_rdata,
      output mem_req, mem_wen, mem_addr, mem_wdata
   );

   modport master (
      output flush, req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  stallreq, excp_ale, resp_valid, resp_err, resp_rdata,
      input  mem_req, mem_wen, mem_addr, mem_wdata
   );

endinterface

// File: rtl/data_sram_load_align.sv
// data_sram_load_align
// Purely combinational load formatter: picks the byte or halfword lane
// addressed by the low address bits out of a 32-bit memory word and zero-
// or sign-extends it to 32 bits. Word loads pass straight through.
// Ports:
//   rdata[31:0]   in   raw memory word
//   addr[1:0]     in   byte offset of the access
//   size          in   access size (size_e)
//   sign_ext      in   1 = sign-extend, 0 = zero-extend
//   rdata32[31:0] out  formatted load result

module data_sram_load_align
   import data_sram_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  size_e       size,
   input  logic        sign_ext,
   output logic [31:0] rdata32
);

   logic [LANE_B-1:0] byte_lane;
   logic [LANE_H-1:0] half_lane;

   // Lane selection; halfwords are aligned so only addr[1] matters for them
   always_comb begin
      byte_lane = rdata[7:0];
      case (addr)
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         2'd3:    byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension to 32 bits according to size and signedness
   always_comb begin
      rdata32 = rdata;
      case (size)
         SZ_B:    rdata32 = {{(32-LANE_B){sign_ext & byte_lane[LANE_B-1]}}, byte_lane};
         SZ_H:    rdata32 = {{(32-LANE_H){sign_ext & half_lane[LANE_H-1]}}, half_lane};
         default: rdata32 = rdata;
      endcase
   end

endmodule

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
// Sequences MEM-stage data accesses over a variable-latency req/ack SRAM
// port. Builds byte strobes and replicated store data, formats load data,
// stalls the pipeline while an access is in flight and flags misaligned
// accesses combinationally.
// Optional build macro: DATA_SRAM_TIMEOUT_EN adds a BUSY wait counter that
// forces completion with resp_err after MAX_WAIT cycles without mem_ack.
// Without it resp_err is tied to 0 and BUSY waits indefinitely.
// Parameters:
//   MAX_WAIT  BUSY cycles without ack before timeout (timeout build only)
//   CNT_W     width of the wait counter, 2**CNT_W > MAX_WAIT
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   bus   data_sram_ctrl_if.slave (request, response and memory signals)

module data_sram_ctrl
   import data_sram_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = 8
)(
   input logic            clk,
   input logic            rst,
   data_sram_ctrl_if.slave bus
);

   state_e      state;
   logic        drop;
   logic        we_q;
   logic        sign_q;
   logic [1:0]  off_q;
   size_e       size_q;
   logic [31:0] rdata_q;
   logic        mem_req_q;
   logic [3:0]  mem_wen_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        resp_valid_q;
   logic        capture;
   logic [3:0]  wen_next;
   logic [31:0] wdata_next;
   logic [31:0] aligned;

`ifdef DATA_SRAM_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   logic             err_q;
`else
   wire unused_cfg = ^{MAX_WAIT, CNT_W};
`endif

   // A request is only taken from IDLE, when aligned and not being flushed
   assign bus.excp_ale = bus.req_valid & (state == IDLE) & is_misaligned(bus.req_size, bus.req_addr[1:0]);
   assign capture      = (state == IDLE) & bus.req_valid & ~bus.excp_ale & ~bus.flush;
   assign bus.stallreq = capture | (state == BUSY);

   // Store strobes and lane-replicated write data for the incoming request
   always_comb begin
      wen_next   = STRB_NONE;
      wdata_next = '0;
      if (bus.req_we) begin
         case (bus.req_size)
            SZ_B: begin
               wen_next   = STRB_B << bus.req_addr[1:0];
               wdata_next = {4{bus.req_wdata[7:0]}};
            end
            SZ_H: begin
               wen_next   = STRB_H << bus.req_addr[1:0];
               wdata_next = {2{bus.req_wdata[15:0]}};
            end
            default: begin
               wen_next   = STRB_W;
               wdata_next = bus.req_wdata;
            end
         endcase
      end
   end

   // Controller FSM; all memory-side outputs and the completion pulse are
   // registered so they stay stable for the whole BUSY phase
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         drop         <= 1'b0;
         we_q         <= 1'b0;
         sign_q       <= 1'b0;
         off_q        <= 2'b00;
         size_q       <= SZ_B;
         rdata_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_wen_q    <= STRB_NONE;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
`ifdef DATA_SRAM_TIMEOUT_EN
         cnt          <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (capture) begin
                  state       <= BUSY;
                  we_q        <= bus.req_we;
                  sign_q      <= bus.req_signed;
                  off_q       <= bus.req_addr[1:0];
                  size_q      <= size_e'(bus.req_size);
                  mem_req_q   <= 1'b1;
                  mem_wen_q   <= wen_next;
                  mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                  mem_wdata_q <= wdata_next;
`ifdef DATA_SRAM_TIMEOUT_EN
                  cnt         <= '0;
`endif
               end
            end
            BUSY: begin
               // A flush here cannot cancel the bus access, only its response
               if (bus.flush) drop <= 1'b1;
               if (bus.mem_ack) begin
                  state        <= DONE;
                  mem_req_q    <= 1'b0;
                  mem_wen_q    <= STRB_NONE;
                  rdata_q      <= bus.mem_rdata;
                  resp_valid_q <= ~(drop | bus.flush);
               end
`ifdef DATA_SRAM_TIMEOUT_EN
               else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
                  state        <= DONE;
                  mem_req_q    <= 1'b0;
                  mem_wen_q    <= STRB_NONE;
                  rdata_q      <= '0;
                  resp_valid_q <= ~(drop | bus.flush);
                  err_q        <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state        <= IDLE;
               drop         <= 1'b0;
               resp_valid_q <= 1'b0;
`ifdef DATA_SRAM_TIMEOUT_EN
               err_q        <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   data_sram_load_align u_align (
      .rdata    (rdata_q),
      .addr     (off_q),
      .size     (size_q),
      .sign_ext (sign_q),
      .rdata32  (aligned)
   );

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_wen    = mem_wen_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.resp_valid = resp_valid_q;
   // Stores return zero; a timed-out access has rdata_q cleared
   assign bus.resp_rdata = ((state == DONE) && !we_q) ? aligned : '0;

`ifdef DATA_SRAM_TIMEOUT_EN
   assign bus.resp_err = err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb_data_sram_ctrl
// Directed self-checking bench for data_sram_ctrl. Inputs are driven on
// the falling clock edge and outputs sampled 1ns later. The timeout
// scenario is compiled only with DATA_SRAM_TIMEOUT_EN (MAX_WAIT = 4).

module tb_data_sram_ctrl;
   import data_sram_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   data_sram_ctrl_if bus();

   data_sram_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Quiet all inputs driven toward the controller
   task automatic idle_inputs();
      bus.flush      = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   // Present one request on the MEM-stage inputs
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
   endtask

   // Reset values, reset dominating a request, and a stray ack in IDLE
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({bus.stallreq, bus.excp_ale, bus.resp_valid, bus.resp_err, bus.mem_req} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags got %b exp 00000", {bus.stallreq, bus.excp_ale, bus.resp_valid, bus.resp_err, bus.mem_req}); end
      checks++; if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== 100'b0) begin errors++; $display("[TB] FAIL reset_data got wen=%h addr=%h wdata=%h rdata=%h exp all 0", bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.resp_rdata); end
      issue(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_blocks_capture got %b exp 0", bus.mem_req); end
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++; if ({bus.resp_valid, bus.mem_req, bus.stallreq} !== 3'b000) begin errors++; $display("[TB] FAIL idle_ack_ignored got %b exp 000", {bus.resp_valid, bus.mem_req, bus.stallreq}); end
   endtask

   // Reset asserted during BUSY abandons the access
   task automatic test_reset_mid();
      @(negedge clk);
      issue(1'b0, SZ_W, 1'b0, 32'h200, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_busy got %b exp 1", bus.mem_req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if ({bus.mem_req, bus.stallreq} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_abandon got %b exp 00", {bus.mem_req, bus.stallreq}); end
      @(negedge clk);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_no_resp got %b exp 0", bus.resp_valid); end
   endtask

   // Signed byte load at offset 3 with the ack in the second BUSY cycle
   task automatic test_load_byte();
      int stall_cycles = 0;
      @(negedge clk);
      issue(1'b0, SZ_B, 1'b1, 32'h1003, 32'h0);
      #1;
      if (bus.stallreq) stall_cycles++;
      checks++; if (bus.excp_ale !== 1'b0) begin errors++; $display("[TB] FAIL lb_ale got %b exp 0", bus.excp_ale); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      if (bus.stallreq) stall_cycles++;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_wen !== 4'b0000 || bus.mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL lb_bus got req=%b wen=%b addr=%h exp 1 0000 00001000", bus.mem_req, bus.mem_wen, bus.mem_addr); end
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80AABBCC;
      #1;
      if (bus.stallreq) stall_cycles++;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      if (bus.stallreq) stall_cycles++;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("[TB] FAIL lb_resp got valid=%b err=%b exp 1 0", bus.resp_valid, bus.resp_err); end
      checks++; if (bus.resp_rdata !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_rdata got %h exp ffffff80", bus.resp_rdata); end
      checks++; if (stall_cycles != 3) begin errors++; $display("[TB] FAIL lb_stall_cycles got %0d exp 3", stall_cycles); end
      @(negedge clk);
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lb_single_pulse got %b exp 0", bus.resp_valid); end
   endtask

   // Lane select and extension across sizes and offsets, ack after 1 cycle
   task automatic test_load_lanes();
      logic [1:0]  sz   [5] = '{SZ_H, SZ_H, SZ_B, SZ_W, SZ_B};
      logic        sg   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ad   [5] = '{32'h802, 32'h800, 32'h801, 32'h804, 32'h806};
      logic [31:0] rd   [5] = '{32'h80017FFF, 32'h00018000, 32'h1234F2AB, 32'hCAFEBABE, 32'h00420000};
      logic [31:0] exp_ [5] = '{32'hFFFF8001, 32'hFFFF8000, 32'h000000F2, 32'hCAFEBABE, 32'h00000042};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
         @(negedge clk);
         bus.req_valid = 1'b0;
         bus.mem_ack = 1'b1; bus.mem_rdata = rd[i];
         @(negedge clk);
         bus.mem_ack = 1'b0;
         #1;
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_[i]) begin errors++; $display("[TB] FAIL load_lane%0d got valid=%b rdata=%h exp 1 %h", i, bus.resp_valid, bus.resp_rdata, exp_[i]); end
      end
   endtask

   // Store strobes, replicated data and word-aligned address
   task automatic test_store();
      logic [1:0]  sz  [4] = '{SZ_H, SZ_B, SZ_W, SZ_B};
      logic [31:0] ad  [4] = '{32'h2002, 32'h5001, 32'h6004, 32'h7003};
      logic [31:0] wd  [4] = '{32'h00001234, 32'hFFFFFFAB, 32'h89ABCDEF, 32'h0000005A};
      logic [3:0]  ewn [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      logic [31:0] ewd [4] = '{32'h12341234, 32'hABABABAB, 32'h89ABCDEF, 32'h5A5A5A5A};
      logic [31:0] ead [4] = '{32'h2000, 32'h5000, 32'h6004, 32'h7000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue(1'b1, sz[i], 1'b0, ad[i], wd[i]);
         @(negedge clk);
         bus.req_valid = 1'b0;
         #1;
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_wen !== ewn[i] || bus.mem_wdata !== ewd[i] || bus.mem_addr !== ead[i]) begin errors++; $display("[TB] FAIL store%0d got req=%b wen=%b wdata=%h addr=%h exp 1 %b %h %h", i, bus.mem_req, bus.mem_wen, bus.mem_wdata, bus.mem_addr, ewn[i], ewd[i], ead[i]); end
         bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
         @(negedge clk);
         bus.mem_ack = 1'b0;
         #1;
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL store%0d_resp got valid=%b rdata=%h exp 1 00000000", i, bus.resp_valid, bus.resp_rdata); end
      end
   endtask

   // Misaligned and illegal-size requests never start an access
   task automatic test_misaligned();
      logic [1:0]  sz [4] = '{SZ_W, SZ_W, SZ_H, SZ_X};
      logic [31:0] ad [4] = '{32'h3001, 32'h3002, 32'h3003, 32'h3000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue(1'b0, sz[i], 1'b0, ad[i], 32'h0);
         #1;
         checks++; if (bus.excp_ale !== 1'b1 || bus.stallreq !== 1'b0) begin errors++; $display("[TB] FAIL ale%0d got ale=%b stall=%b exp 1 0", i, bus.excp_ale, bus.stallreq); end
         @(negedge clk);
         #1;
         checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ale%0d_no_req got %b exp 0", i, bus.mem_req); end
      end
      bus.req_valid = 1'b0;
   endtask

   // Flush in BUSY drops the response; flush in IDLE blocks capture
   task automatic test_flush();
      @(negedge clk);
      issue(1'b0, SZ_H, 1'b0, 32'h4002, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.flush = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.stallreq !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy got req=%b stall=%b exp 1 1", bus.mem_req, bus.stallreq); end
      @(negedge clk);
      bus.flush = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBEEF0000;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++; if ({bus.resp_valid, bus.stallreq, bus.mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL flush_drop got %b exp 000", {bus.resp_valid, bus.stallreq, bus.mem_req}); end
      @(negedge clk);
      issue(1'b0, SZ_W, 1'b0, 32'h4000, 32'h0);
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_stall got %b exp 0", bus.stallreq); end
      @(negedge clk);
      bus.req_valid = 1'b0; bus.flush = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_blocked got %b exp 0", bus.mem_req); end
      issue(1'b0, SZ_W, 1'b0, 32'h4004, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00000055;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h55) begin errors++; $display("[TB] FAIL flush_recover got valid=%b rdata=%h exp 1 00000055", bus.resp_valid, bus.resp_rdata); end
   endtask

   // Two loads with the request held through DONE; no duplicate capture
   task automatic test_back_to_back();
      int pulses = 0;
      int first  = -1;
      int second = -1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c < 5) issue(1'b0, SZ_W, 1'b0, (c < 3) ? 32'h10 : 32'h14, 32'h0);
         else bus.req_valid = 1'b0;
         bus.mem_ack   = (c == 1 || c == 4);
         bus.mem_rdata = (c == 1) ? 32'h11111111 : 32'h22222222;
         #1;
         if (bus.resp_valid === 1'b1) begin
            pulses++;
            if (first < 0) first = c; else second = c;
         end
         if (c == 2) begin
            checks++; if (bus.stallreq !== 1'b0 || bus.resp_rdata !== 32'h11111111) begin errors++; $display("[TB] FAIL b2b_done1 got stall=%b rdata=%h exp 0 11111111", bus.stallreq, bus.resp_rdata); end
         end
         if (c == 3) begin
            checks++; if (bus.mem_req !== 1'b0 || bus.stallreq !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_dup got req=%b stall=%b exp 0 1", bus.mem_req, bus.stallreq); end
         end
         if (c == 4) begin
            checks++; if (bus.mem_addr !== 32'h14) begin errors++; $display("[TB] FAIL b2b_addr2 got %h exp 00000014", bus.mem_addr); end
         end
         if (c == 5) begin
            checks++; if (bus.resp_rdata !== 32'h22222222) begin errors++; $display("[TB] FAIL b2b_done2 got %h exp 22222222", bus.resp_rdata); end
         end
      end
      bus.mem_ack = 1'b0;
      checks++; if (pulses != 2 || (second - first) != 3) begin errors++; $display("[TB] FAIL b2b_pulses got count=%0d gap=%0d exp 2 3", pulses, second - first); end
   endtask

`ifdef DATA_SRAM_TIMEOUT_EN
   // No ack: completion with resp_err after MAX_WAIT (4) BUSY cycles
   task automatic test_timeout();
      int busy_cycles = 0;
      int guard = 0;
      @(negedge clk);
      issue(1'b0, SZ_W, 1'b0, 32'h6000, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      while (bus.mem_req === 1'b1 && guard < 20) begin
         busy_cycles++;
         guard++;
         @(negedge clk);
         #1;
      end
      checks++; if (busy_cycles != 4) begin errors++; $display("[TB] FAIL timeout_busy_cycles got %0d exp 4", busy_cycles); end
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL timeout_resp got valid=%b err=%b rdata=%h exp 1 1 00000000", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++; if ({bus.resp_valid, bus.resp_err, bus.mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL timeout_stray_ack got %b exp 000", {bus.resp_valid, bus.resp_err, bus.mem_req}); end
   endtask
`endif

   initial begin
      $display("[TB] start");
      test_reset();
      test_reset_mid();
      test_load_byte();
      test_load_lanes();
      test_store();
      test_misaligned();
      test_flush();
      test_back_to_back();
`ifdef DATA_SRAM_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
